image_half_downsample: RTL and testbench

- Halves a raster-scanned greyscale image in both dimensions: input 2*NEW_WIDTH x 2*NEW_WIDTH, output NEW_WIDTH x NEW_WIDTH.
- Each output pixel is the truncated mean of one 2x2 input block.
- Sits between the pixel-stream source (camera/BRAM reader) and a downstream frame buffer, which it addresses with a linear output address.

---
 rtl/image_half_downsample.sv | 99 +++++++++
 tb/tb_image_half_downsample.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_half_downsample.sv
// Halves a raster-scanned square greyscale image in both dimensions (2x2 block -> 1 pixel).
// Define IMAGE_HALF_AVG_EN for a truncated 2x2 box average; otherwise the top-left pixel is kept.
module image_half_downsample #(
    parameter int BIT_DEPTH = 8,
    parameter int NEW_WIDTH = 32
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [BIT_DEPTH-1:0]             data_in,
    input  logic [$clog2(2*NEW_WIDTH)-1:0]   data_x_in,
    input  logic [$clog2(2*NEW_WIDTH)-1:0]   data_y_in,
    input  logic                             data_valid_in,
    output logic [BIT_DEPTH-1:0]             data_out,
    output logic [2*$clog2(NEW_WIDTH)-1:0]   data_addr_out,
    output logic                             data_valid_out
);

    localparam int XW = $clog2(2*NEW_WIDTH);
    localparam int AW = $clog2(NEW_WIDTH);
`ifdef IMAGE_HALF_AVG_EN
    localparam int LBW = BIT_DEPTH + 1;
`else
    localparam int LBW = BIT_DEPTH;
`endif

    logic [BIT_DEPTH-1:0] hold_q, hold_d;
    logic [BIT_DEPTH-1:0] data_out_q, data_out_d;
    logic [2*AW-1:0]      addr_q, addr_d;
    logic                 valid_q, valid_d;

    logic [AW-1:0]        x_half, y_half;
    logic                 lb_we;
    logic [LBW-1:0]       lb_wdata;
    logic [LBW-1:0]       lb_rd;
    logic [LBW-1:0]       linebuf [NEW_WIDTH];

    assign x_half = data_x_in[XW-1:1];
    assign y_half = data_y_in[XW-1:1];
    assign lb_rd  = linebuf[x_half];

`ifdef IMAGE_HALF_AVG_EN
    logic [BIT_DEPTH:0]   hsum;
    logic [BIT_DEPTH+1:0] total;
    assign hsum     = {1'b0, hold_q} + {1'b0, data_in};
    assign total    = {1'b0, lb_rd} + {1'b0, hsum};
    assign lb_wdata = hsum;
`else
    assign lb_wdata = hold_q;
`endif

    always_comb begin
        hold_d     = hold_q;
        data_out_d = data_out_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        lb_we      = 1'b0;
        if (data_valid_in) begin
            if (!data_x_in[0]) begin
                hold_d = data_in;
            end else if (!data_y_in[0]) begin
                lb_we = 1'b1;
            end else begin
                valid_d = 1'b1;
                addr_d  = {y_half, x_half};
`ifdef IMAGE_HALF_AVG_EN
                data_out_d = total[BIT_DEPTH+1:2];
`else
                data_out_d = lb_rd;
`endif
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold_q     <= '0;
            data_out_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
        end
    end

    // Line buffer carries even-row partial results to the odd row; no reset needed.
    always_ff @(posedge clk_in) begin
        if (lb_we) begin
            linebuf[x_half] <= lb_wdata;
        end
    end

    assign data_out       = data_out_q;
    assign data_addr_out  = addr_q;
    assign data_valid_out = valid_q;

endmodule

// File: tb/tb_image_half_downsample.sv
// Self-checking bench for image_half_downsample: block-level image model plus directed literal checks.
module tb_image_half_downsample;

    localparam int BD = 8;
    localparam int NW = 32;
    localparam int XW = 6;
    localparam int AW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [BD-1:0] data_in;
    logic [XW-1:0] data_x_in, data_y_in;
    logic          data_valid_in;
    logic [BD-1:0] data_out;
    logic [2*AW-1:0] data_addr_out;
    logic          data_valid_out;

    image_half_downsample #(.BIT_DEPTH(BD), .NEW_WIDTH(NW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in),
        .data_x_in(data_x_in), .data_y_in(data_y_in), .data_valid_in(data_valid_in),
        .data_out(data_out), .data_addr_out(data_addr_out), .data_valid_out(data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Image as the model sees it: img[y][x], updated only by valid inputs.
    int img [64][64];

    int pend_v = 0, pend_d = 0, pend_a = 0;
    int last_d = 0, last_a = 0;
    int strobe_cnt = 0, first_d = -1, first_a = -1, final_d = -1, final_a = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pix(input int xh, input int yh);
`ifdef IMAGE_HALF_AVG_EN
        int s;
        s = img[2*yh][2*xh] + img[2*yh][2*xh+1] + img[2*yh+1][2*xh] + img[2*yh+1][2*xh+1];
        return s / 4;
`else
        return img[2*yh][2*xh];
`endif
    endfunction

    // Expectation for the cycle after each edge: a strobe follows every valid (odd x, odd y) input.
    initial forever begin
        @(posedge clk_in);
        if (rst_in) begin
            pend_v = 0;
        end else begin
            pend_v = (data_valid_in && data_x_in[0] && data_y_in[0]) ? 1 : 0;
            pend_d = model_pix(int'(data_x_in) / 2, int'(data_y_in) / 2);
            pend_a = (int'(data_y_in) / 2) * NW + int'(data_x_in) / 2;
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (rst_in) begin
            chk("rst_valid", int'(data_valid_out), 0);
            chk("rst_data", int'(data_out), 0);
            chk("rst_addr", int'(data_addr_out), 0);
            last_d = 0;
            last_a = 0;
            pend_v = 0;
        end else begin
            chk("strobe", int'(data_valid_out), pend_v);
            if (pend_v != 0) begin
                chk("data", int'(data_out), pend_d);
                chk("addr", int'(data_addr_out), pend_a);
                last_d = pend_d;
                last_a = pend_a;
            end else begin
                chk("hold_data", int'(data_out), last_d);
                chk("hold_addr", int'(data_addr_out), last_a);
            end
            if (data_valid_out) begin
                strobe_cnt++;
                if (strobe_cnt == 1) begin
                    first_d = int'(data_out);
                    first_a = int'(data_addr_out);
                end
                final_d = int'(data_out);
                final_a = int'(data_addr_out);
            end
        end
    end

    task automatic drive(input int x, input int y, input int v);
        @(negedge clk_in);
        data_valid_in = 1'b1;
        data_x_in = XW'(x);
        data_y_in = XW'(y);
        data_in = BD'(v);
        img[y][x] = v;
    endtask

    task automatic drive_garbage();
        @(negedge clk_in);
        data_valid_in = 1'b0;
        data_x_in = XW'($urandom);
        data_y_in = XW'($urandom);
        data_in = BD'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        data_valid_in = 1'b0;
        #1;
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_addr", int'(data_addr_out), 0);
        chk("async_rst_valid", int'(data_valid_out), 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic send_frame(input int gap, input int abort_row);
        strobe_cnt = 0;
        for (int y = 0; y < 2*NW; y++) begin
            for (int x = 0; x < 2*NW; x++) begin
                if (y == abort_row && x == 0) begin
                    do_reset();
                    return;
                end
                drive(x, y, x + y);
                if (gap != 0) drive_garbage();
            end
        end
        idle(3);
        $display("frame gap=%0d: strobes=%0d first=%0d@%0d last=%0d@%0d",
                 gap, strobe_cnt, first_d, first_a, final_d, final_a);
    endtask

    task automatic frame_literals(input string tag);
        chk({tag, "_count"}, strobe_cnt, 1024);
`ifdef IMAGE_HALF_AVG_EN
        chk({tag, "_first_data"}, first_d, 1);
        chk({tag, "_last_data"}, final_d, 125);
`else
        chk({tag, "_first_data"}, first_d, 0);
        chk({tag, "_last_data"}, final_d, 124);
`endif
        chk({tag, "_first_addr"}, first_a, 0);
        chk({tag, "_last_addr"}, final_a, 1023);
    endtask

    task automatic send_block(input int a, input int b, input int c, input int d, input int exp);
        drive(0, 0, a);
        drive(1, 0, b);
        drive(0, 1, c);
        drive(1, 1, d);
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        chk("blk_strobe_hi", int'(data_valid_out), 1);
        chk("blk_data", int'(data_out), exp);
        chk("blk_addr", int'(data_addr_out), 0);
        @(posedge clk_in);
        #1;
        chk("blk_strobe_lo", int'(data_valid_out), 0);
        $display("block {%0d,%0d,%0d,%0d}: out=%0d", a, b, c, d, int'(data_out));
    endtask

    initial begin
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                img[y][x] = 0;
        rst_in = 1'b1;
        data_valid_in = 1'b0;
        data_in = '0;
        data_x_in = '0;
        data_y_in = '0;
        #1;
        chk("init_rst_data", int'(data_out), 0);
        chk("init_rst_addr", int'(data_addr_out), 0);
        chk("init_rst_valid", int'(data_valid_out), 0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

`ifdef IMAGE_HALF_AVG_EN
        send_block(255, 255, 255, 254, 254);
        send_block(0, 0, 0, 3, 0);
        send_block(255, 255, 255, 255, 255);
`else
        send_block(255, 255, 255, 254, 255);
        send_block(0, 0, 0, 3, 0);
        send_block(255, 255, 255, 255, 255);
`endif
        idle(2);
        do_reset();
        idle(2);

        send_frame(1, -1);
        frame_literals("gap_frame");
        send_frame(0, -1);
        frame_literals("dense_frame");

        send_frame(1, 10);
        idle(2);
        send_frame(1, -1);
        frame_literals("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
